// File: rtl/perf_counter_ctrl_if.sv
// Host register bus for perf_counter_ctrl: a request is held until the one-cycle
// resp pulse, and rdata is valid while resp is high.
interface perf_counter_ctrl_if;
    logic        req_read;
    logic        req_write;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        resp;

    modport master (
        output req_read, req_write, addr, wdata,
        input  rdata, resp
    );

    modport slave (
        input  req_read, req_write, addr, wdata,
        output rdata, resp
    );
endinterface

// File: rtl/perf_counter_ctrl.sv
// Performance counter block: up to four thresholded event counters behind a small host register bus.
// Optional overflow interrupt is enabled by defining PERF_OVF_IRQ_EN.
module perf_counter_ctrl #(
    parameter int NUM_SLOTS  = 4,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_EVENTS-1:0] event_in,
    perf_counter_ctrl_if.slave    bus,
    output logic                  irq
);

    typedef enum logic {S_IDLE, S_RESP} state_t;

    state_t      state_reg, state_next;
    logic        resp_int;
    logic        do_read, do_write;
    logic        wr_global, wr_status, clear_all;
    logic        freeze_reg;
    logic [3:0]  status_reg, status_next;
    logic [3:0]  ovf_vec;
    logic [15:0] rdata_reg, read_mux;
    logic [7:0]  ev_pad;

    logic [15:0] count_w [4];
    logic [15:0] cfg_w   [4];
    logic        ovf_w   [4];

    // Upper write-data bits have no storage behind them.
    logic unused_wdata;
    assign unused_wdata = ^bus.wdata[15:9];

    // ---------------- host FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) state_reg <= S_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: if (bus.req_read || bus.req_write) state_next = S_RESP;
            S_RESP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Reads win over writes; requests are only accepted in IDLE.
    always_comb begin
        resp_int = (state_reg == S_RESP);
        do_read  = (state_reg == S_IDLE) && bus.req_read;
        do_write = (state_reg == S_IDLE) && bus.req_write && !bus.req_read;
    end

    // A reset arriving in RESP kills the pulse immediately, not just on the next cycle.
    assign bus.resp  = resp_int && !reset;
    assign bus.rdata = rdata_reg;

    assign wr_global = do_write && (bus.addr == 4'd8);
    assign wr_status = do_write && (bus.addr == 4'd9);
    assign clear_all = wr_global && bus.wdata[1];

    always_comb begin
        ev_pad = '0;
        for (int i = 0; i < NUM_EVENTS; i++) ev_pad[i] = event_in[i];
    end

    // ---------------- counter slots ----------------
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            if (gi < NUM_SLOTS) begin : g_live
                logic [15:0] count_reg;
                logic [3:0]  run_reg;
                logic        fired_reg;
                logic [8:0]  cfg_reg;
                logic        sel_event, slot_clear, active, at_thresh, hit;

                assign sel_event  = ev_pad[cfg_reg[2:0]];
                assign slot_clear = clear_all || (do_write && (bus.addr == 4'(gi)));
                assign active     = cfg_reg[8] && !freeze_reg;
                assign at_thresh  = (run_reg == cfg_reg[6:3]);
                assign hit        = active && sel_event && at_thresh && (!fired_reg || cfg_reg[7]);

                always_ff @(posedge clk) begin
                    if (reset)
                        cfg_reg <= '0;
                    else if (do_write && (bus.addr == 4'(gi + 4)))
                        cfg_reg <= bus.wdata[8:0];
                end

                // Host clear outranks any increment landing on the same edge.
                always_ff @(posedge clk) begin
                    if (reset || slot_clear) begin
                        count_reg <= '0;
                        run_reg   <= '0;
                        fired_reg <= 1'b0;
                    end else if (active) begin
                        if (!sel_event) begin
                            run_reg   <= '0;
                            fired_reg <= 1'b0;
                        end else if (!at_thresh) begin
                            run_reg <= run_reg + 4'd1;
                        end else if (hit) begin
                            fired_reg <= 1'b1;
                            if (count_reg != 16'hFFFF) count_reg <= count_reg + 16'd1;
                        end
                    end
                end

                assign count_w[gi] = count_reg;
                assign cfg_w[gi]   = {7'b0, cfg_reg};
                assign ovf_w[gi]   = hit && !slot_clear && (count_reg == 16'hFFFF);
            end else begin : g_absent
                assign count_w[gi] = '0;
                assign cfg_w[gi]   = '0;
                assign ovf_w[gi]   = 1'b0;
            end
        end
    endgenerate

    // ---------------- global / status ----------------
    always_ff @(posedge clk) begin
        if (reset)          freeze_reg <= 1'b0;
        else if (wr_global) freeze_reg <= bus.wdata[0];
    end

    always_comb begin
        ovf_vec = '0;
        for (int i = 0; i < 4; i++) ovf_vec[i] = ovf_w[i];
    end

    // New overflow is OR'd in after the clear so it survives a same-cycle W1C.
    always_comb begin
        status_next = status_reg;
        if (wr_status) status_next = status_reg & ~bus.wdata[3:0];
        status_next = status_next | ovf_vec;
    end

    always_ff @(posedge clk) begin
        if (reset) status_reg <= '0;
        else       status_reg <= status_next;
    end

    // ---------------- read path ----------------
    always_comb begin
        read_mux = '0;
        case (bus.addr)
            4'd0, 4'd1, 4'd2, 4'd3: read_mux = count_w[bus.addr[1:0]];
            4'd4, 4'd5, 4'd6, 4'd7: read_mux = cfg_w[bus.addr[1:0]];
            4'd8:                   read_mux = {15'b0, freeze_reg};
            4'd9:                   read_mux = {12'b0, status_reg};
            default:                read_mux = '0;
        endcase
    end

    // Captured from pre-edge state, so a read never sees a same-cycle increment.
    always_ff @(posedge clk) begin
        if (reset)         rdata_reg <= '0;
        else if (do_read)  rdata_reg <= read_mux;
        else if (do_write) rdata_reg <= '0;
    end

`ifdef PERF_OVF_IRQ_EN
    logic irq_reg;
    always_ff @(posedge clk) begin
        if (reset) irq_reg <= 1'b0;
        else       irq_reg <= |status_reg;
    end
    assign irq = irq_reg;
`else
    assign irq = 1'b0;
`endif

endmodule
